// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between a producer and the serial subtractor.
interface serial_subtractor_if
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;

   // master offers operands and consumes results; slave is the subtractor
   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout
   );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor; the serial datapath reuses this single cell every cycle.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first, borrow kept in a flop.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_aShift;
   logic [WIDTH-1:0] r_bShift;
   logic [WIDTH-1:0] r_diffShift;
   logic             r_borrow;
   logic [CW-1:0]    r_count;
   logic             r_outValid;
   logic             r_inReady;
   logic             r_bout;

   logic             w_diffBit;
   logic             w_borrowNext;
   logic [WIDTH-1:0] w_diffNext;

   full_subtractor u_fullSub (
      .a    (r_aShift[0]),
      .b    (r_bShift[0]),
      .bin  (r_borrow),
      .diff (w_diffBit),
      .bout (w_borrowNext)
   );

   // New result bit enters at the MSB so the word is aligned after WIDTH shifts
   always_comb begin
      w_diffNext            = r_diffShift >> 1;
      w_diffNext[WIDTH-1]   = w_diffBit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_aShift    <= '0;
         r_bShift    <= '0;
         r_diffShift <= '0;
         r_borrow    <= 1'b0;
         r_count     <= '0;
         r_outValid  <= 1'b0;
         r_bout      <= 1'b0;
         r_inReady   <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_aShift  <= bus.a;
                  r_bShift  <= bus.b;
                  r_borrow  <= bus.bin;
                  r_count   <= '0;
                  r_inReady <= 1'b0;
                  r_state   <= CALC;
               end
            end
            CALC: begin
               r_aShift    <= r_aShift >> 1;
               r_bShift    <= r_bShift >> 1;
               r_diffShift <= w_diffNext;
               r_borrow    <= w_borrowNext;
               r_count     <= r_count + CW'(1);
               // Final bit: the borrow out of the MSB is the result borrow
               if (r_count == LAST) begin
                  r_outValid <= 1'b1;
                  r_bout     <= w_borrowNext;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_outValid <= 1'b0;
                  r_bout     <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.diff      = r_diffShift;
   assign bus.bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;
   import sub_pkg::*;

   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Offer operands in IDLE and return at the negedge of the first CALC cycle
   task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input logic opBin);
      bus.in_valid = 1'b1;
      bus.a        = opA;
      bus.b        = opB;
      bus.bin      = opBin;
      checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("in_ready_in_calc", 32'(bus.in_ready), 32'd0);
   endtask

   task automatic waitResult(input int firstEdge);
      for (int i = firstEdge; i <= WIDTH; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("out_valid_after_edge%0d", i), 32'(bus.out_valid), (i == WIDTH) ? 32'd1 : 32'd0);
         if (i < WIDTH)
            checkOutput($sformatf("bout_low_edge%0d", i), 32'(bus.bout), 32'd0);
      end
   endtask

   task automatic checkResult(input string tag, input logic [WIDTH-1:0] expDiff, input logic expBout);
      checkOutput({tag, "_diff"}, 32'(bus.diff), 32'(expDiff));
      checkOutput({tag, "_bout"}, 32'(bus.bout), 32'(expBout));
   endtask

   task automatic retire();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("out_valid_after_retire", 32'(bus.out_valid), 32'd0);
      checkOutput("in_ready_after_retire", 32'(bus.in_ready), 32'd1);
      checkOutput("bout_after_retire", 32'(bus.bout), 32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] heldDiff;
      logic             heldBout;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.bin       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_bout", 32'(bus.bout), 32'd0);
      checkOutput("reset_diff", 32'(bus.diff), 32'd0);

      $display("[TB] 9-3-0");
      applyStimulus(4'd9, 4'd3, 1'b0);
      waitResult(1);
      checkResult("sub_9_3", 4'd6, 1'b0);
      retire();

      $display("[TB] 3-9-0 with 5-cycle stall in DONE");
      applyStimulus(4'd3, 4'd9, 1'b0);
      waitResult(1);
      checkResult("sub_3_9", 4'd10, 1'b1);
      heldDiff = bus.diff;
      heldBout = bus.bout;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("stall_diff", 32'(bus.diff), 32'd10);
         checkOutput("stall_bout", 32'(bus.bout), 32'd1);
         checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      checkOutput("stall_diff_held", 32'(bus.diff), 32'(heldDiff));
      checkOutput("stall_bout_held", 32'(bus.bout), 32'(heldBout));
      // Operands offered on the retiring edge must not be taken
      bus.in_valid = 1'b1;
      bus.a        = 4'd5;
      bus.b        = 4'd1;
      retire();
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("no_accept_on_retire", 32'(bus.in_ready), 32'd1);

      $display("[TB] 0-0-1");
      applyStimulus(4'd0, 4'd0, 1'b1);
      waitResult(1);
      checkResult("sub_0_0_1", 4'd15, 1'b1);
      retire();

      $display("[TB] 15-15-0");
      applyStimulus(4'd15, 4'd15, 1'b0);
      waitResult(1);
      checkResult("sub_15_15", 4'd0, 1'b0);
      retire();

      $display("[TB] 15-0-1 with out_ready held high throughout");
      bus.out_ready = 1'b1;
      applyStimulus(4'd15, 4'd0, 1'b1);
      waitResult(1);
      checkResult("sub_15_0_1", 4'd14, 1'b0);
      retire();

      $display("[TB] 9-3-0 with in_valid pulse during CALC");
      applyStimulus(4'd9, 4'd3, 1'b0);
      bus.in_valid = 1'b1;
      bus.a        = 4'd1;
      bus.b        = 4'd1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("pulse_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("pulse_out_valid", 32'(bus.out_valid), 32'd0);
      waitResult(2);
      checkResult("sub_9_3_pulse", 4'd6, 1'b0);
      retire();
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("pulse_never_accepted", 32'(bus.out_valid), 32'd0);
         checkOutput("pulse_idle_ready", 32'(bus.in_ready), 32'd1);
      end

      $display("[TB] reset during CALC, then 7-2-0");
      applyStimulus(4'd9, 4'd3, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("abort_bout", 32'(bus.bout), 32'd0);
      repeat (WIDTH) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("abort_no_partial", 32'(bus.out_valid), 32'd0);
      end
      applyStimulus(4'd7, 4'd2, 1'b0);
      waitResult(1);
      checkResult("sub_7_2", 4'd5, 1'b0);
      retire();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand/difference width in bits; legal range WIDTH >= 1.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operand set is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, minuend and subtrahend (unsigned).
REQ-007 The block SHALL have port bin, input, 1, borrow-in.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is available.
REQ-009 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 The block SHALL have port diff, output, WIDTH, the difference.
REQ-011 The block SHALL have port bout, output, 1, the borrow-out.

Function
REQ-012 The block SHALL compute diff = (a - b - bin) mod 2^WIDTH and bout = 1 exactly when a < b + bin (unsigned).
REQ-013 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on a clock edge with in_valid=1, the block SHALL capture a, b and bin, clear the bit counter, and go to CALC.
REQ-015 In CALC, the block SHALL process one bit per clock, LSB first: diff_bit = a_i ^ b_i ^ borrow and borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow); the borrow register starts at the captured bin.
REQ-016 The block SHALL leave CALC for DONE on the WIDTH-th CALC edge, so out_valid rises exactly WIDTH clocks after the accepting edge.
REQ-017 In DONE, out_valid SHALL be 1 and diff/bout SHALL be held stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-018 in_ready SHALL be 0 in CALC and DONE, and in_valid/a/b/bin SHALL be ignored in those states.
REQ-019 The block SHALL not accept new operands on the same edge that retires a result; in_ready reasserts on the cycle after.
REQ-020 out_ready asserted outside DONE SHALL have no effect.
REQ-021 diff SHALL not be required to be meaningful while out_valid=0; bout SHALL be 0 while out_valid=0.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL not wrap during a valid operation.
REQ-023 For WIDTH=1, the block SHALL spend one cycle in CALC.

Reset
REQ-024 On an edge with rst_n=0, the FSM SHALL go to IDLE, and out_valid=0, bout=0, diff=0, counter=0 and borrow=0 SHALL be set; in_ready SHALL be 1 in the first cycle after reset.
REQ-025 Reset asserted in CALC or DONE SHALL abort the operation, discard the result, and never produce a partial out_valid.

Structure
REQ-026 Package sub_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the DEFAULT_WIDTH=4 constant.
REQ-027 The per-bit logic SHALL be one combinational sub-module, full_subtractor, with ports a, b, bin, diff and bout; it SHALL be instantiated once, and the borrow chain is formed through the borrow register.
REQ-028 The datapath SHALL consist of shift registers for a, b and diff plus a single borrow flip-flop; no WIDTH-wide subtractor is permitted.

Verification (WIDTH=4)
REQ-029 Bench SHALL cover: a=9, b=3, bin=0 -> diff=6, bout=0, with out_valid exactly 4 clocks after acceptance.
REQ-030 Bench SHALL cover: a=3, b=9, bin=0 -> diff=10, bout=1; and a=0, b=0, bin=1 -> diff=15, bout=1.
REQ-031 Bench SHALL cover: a=15, b=15, bin=0 -> diff=0, bout=0; and a=15, b=0, bin=1 -> diff=14, bout=0.
REQ-032 Bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid, diff and bout stay constant, and in_ready stays 0; then out_ready=1 for one edge -> IDLE and in_ready=1 on the next cycle.
REQ-033 Bench SHALL cover: in_valid pulsed with a=1, b=1 during CALC of a 9-3 operation -> the result is still 6/0, and the second operand set is never accepted.
REQ-034 Bench SHALL cover: rst_n=0 on the 2nd CALC cycle -> the next cycle shows in_ready=1, out_valid=0 and bout=0, and a following 7-2 operation yields 5/0.
